key_debounce: RTL and testbench
===============================

# key_debounce

Debounces and conditions one raw active-low board pushbutton into clean, single-cycle control events for the random-number core. Its `o_press` drives the core's `i_start` directly. `o_level`, `o_release` and `o_long` are available to the top level for display and mode control. The block synchronizes the asynchronous key, rejects bounce shorter than a programmable window, and flags long holds.

## Interface
Parameters:
- `STABLE_CYCLES`, default 500_000: consecutive stable samples required to accept a press or a release (10 ms at 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, default 50_000_000: cycles in the pressed state before `o_long` fires (1 s at 50 MHz); must be > `STABLE_CYCLES`.
- `CNT_W`, default 26: counter width; must hold `LONG_CYCLES`.

Ports:
- `i_clk`, in, 1: single clock; all logic is on its rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_key_n`, in, 1: raw pushbutton, 0 = pressed, asynchronous to `i_clk`.
- `o_level`, out, 1: debounced state, 1 = pressed.
- `o_press`, out, 1: one-cycle pulse on an accepted press.
- `o_release`, out, 1: one-cycle pulse on an accepted release.
- `o_long`, out, 1: one-cycle pulse, at most once per press, when the hold reaches `LONG_CYCLES`.

## Operation
- Synchronizer: two flops sample `~i_key_n`, giving `key_s` with 1 = pressed. Both flops reset to 0.
- FSM states:
  - `S_RELEASED`
    - `key_s=1`: go to `S_PRESS_WAIT`, set `cnt=1`.
  - `S_PRESS_WAIT`
    - `key_s=0`: return to `S_RELEASED`, set `cnt=0`.
    - `key_s=1` and `cnt==STABLE_CYCLES-1`: go to `S_PRESSED`, set `cnt=0`, `o_level=1`, `o_press=1`.
    - Otherwise: `cnt++`.
  - `S_PRESSED`
    - `key_s=0`: go to `S_RELEASE_WAIT`, set `cnt=1`.
    - `key_s=1`: `cnt` increments, saturating at `LONG_CYCLES`. `o_long=1` for exactly the cycle after `cnt` reaches `LONG_CYCLES-1`.
  - `S_RELEASE_WAIT`
    - `key_s=1`: return to `S_PRESSED` with `cnt` saturated at `LONG_CYCLES`, so no second `o_long` is possible.
    - `key_s=0` and `cnt==STABLE_CYCLES-1`: go to `S_RELEASED`, set `cnt=0`, `o_level=0`, `o_release=1`.
    - Otherwise: `cnt++`.
- Outputs are registered. Pulses default to 0 every cycle.
- The confirmation sample counts: if the input bounces on the same cycle the window would complete, the FSM reverts and no pulse is issued.
- One `cnt` register is shared by all states. Its arithmetic is unsigned and it never wraps; in `S_PRESSED` it saturates.
- Behaviour is equivalent for any `i_key_n` pattern shorter than `STABLE_CYCLES`: no output change.

## Timing
- Reset (`i_rst=1` at an edge):
  - State goes to `S_RELEASED`; `cnt`, both synchronizer flops and all outputs go to 0 on that edge.
  - Reset has priority over all other activity, including in any wait state or in the middle of a pulse.
- Edge numbering for latency: edge 0 is the first edge sampling `i_key_n=0`, with the key held low.
  - `key_s=1` after edge 1.
  - `S_PRESS_WAIT` is entered at edge 2.
  - `o_press` and `o_level` rise at edge `STABLE_CYCLES+1`.
- Release latency is symmetric: `o_release` at edge `STABLE_CYCLES+1` after the first high sample.
- `o_long` rises `LONG_CYCLES` edges after `o_press`.
- A key held through reset produces a fresh `o_press` `STABLE_CYCLES+1` edges after the first edge with `i_rst=0`.
- Pulses never overlap. `o_press` and `o_release` are at least `STABLE_CYCLES` cycles apart.

## Structure
- Package `key_debounce_pkg`:
  - state enum `debounce_state_t` with 2-bit encoding;
  - default constants `DEB_STABLE_DEFAULT`, `DEB_LONG_DEFAULT`, `DEB_CNT_W`.
- Sub-module `sync_2ff`: parameter-free 1-bit two-flop synchronizer with synchronous active-high reset. It is reused for other board inputs.
- Parameter legality is checked by an elaboration-time assertion in `key_debounce`.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `LONG_CYCLES=10`, `CNT_W=4`.
1. Clean press: after reset, `i_key_n=0` held 20 cycles → single `o_press` at edge 5, `o_level` 1 from edge 5, no `o_release`.
2. Bounce: `i_key_n` low 3 cycles, high 1, low 8 → no output during bounce; single `o_press` at edge 5 counted from the restart; `o_level` stable 1.
3. Long hold: key held 30 cycles → `o_long` once, exactly 10 edges after `o_press`; a 2-cycle release glitch later produces no second `o_long` and no `o_release`.
4. Release: release after scenario 1 → `o_release` at edge 5 after the first high sample; `o_level` falls the same edge.
5. Reset mid-operation: assert `i_rst` during `S_PRESS_WAIT` and again during `S_PRESSED` with the key held → all outputs 0 after that edge, no pulse; fresh `o_press` 5 edges after reset release.
6. Glitch train: 1-cycle low pulses every 3 cycles for 50 cycles → every output stays 0.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and default constants for the pushbutton debouncer.
// Defaults assume a 50 MHz clock: 10 ms bounce window, 1 s long hold.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'b00,
        S_PRESS_WAIT   = 2'b01,
        S_PRESSED      = 2'b10,
        S_RELEASE_WAIT = 2'b11
    } debounce_state_t;

    localparam int unsigned DEB_STABLE_DEFAULT = 32'd500_000;
    localparam int unsigned DEB_LONG_DEFAULT   = 32'd50_000_000;
    localparam int unsigned DEB_CNT_W          = 32'd26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input.
// Both stages clear on synchronous active-high reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic sync1_r;
    logic sync2_r;

    // Metastability filter: first stage may go metastable, second stage is used.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_d;
            sync2_r <= sync1_r;
        end
    end

    assign o_q = sync2_r;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low pushbutton into a clean level plus single-cycle
// press, release and long-hold pulses. All outputs are registered.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int unsigned LONG_CYCLES   = DEB_LONG_DEFAULT,
    parameter int unsigned CNT_W         = DEB_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    if ((STABLE_CYCLES < 32'd2) || (LONG_CYCLES <= STABLE_CYCLES) ||
        (64'(LONG_CYCLES) >= (64'd1 << CNT_W))) begin : g_param_check
        $error("key_debounce: illegal STABLE_CYCLES/LONG_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LONG_SAT    = CNT_W'(LONG_CYCLES);

    logic             key_s;
    debounce_state_t  state_r;
    debounce_state_t  state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_r;
    logic             level_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             release_r;
    logic             release_nxt_s;
    logic             long_r;
    logic             long_nxt_s;

    sync_2ff u_key_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (~i_key_n),
        .o_q   (key_s)
    );

    // State, shared counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= S_RELEASED;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            long_r    <= long_nxt_s;
        end
    end

    // Next state and counter; a bounce on the confirming sample still reverts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_RELEASED: begin
                if (key_s) begin
                    state_nxt_s = S_PRESS_WAIT;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            S_PRESS_WAIT: begin
                if (!key_s) begin
                    state_nxt_s = S_RELEASED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = S_PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!key_s) begin
                    state_nxt_s = S_RELEASE_WAIT;
                    cnt_nxt_s   = CNT_ONE;
                end else if (cnt_r < LONG_SAT) begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s   = LONG_SAT;
                end
            end
            S_RELEASE_WAIT: begin
                // Returning to pressed re-enters saturated so o_long cannot repeat.
                if (key_s) begin
                    state_nxt_s = S_PRESSED;
                    cnt_nxt_s   = LONG_SAT;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = S_RELEASED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = S_RELEASED;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode: level holds, pulses default low every cycle.
    always_comb begin
        level_nxt_s   = level_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        long_nxt_s    = 1'b0;
        case (state_r)
            S_RELEASED: begin
                level_nxt_s = 1'b0;
            end
            S_PRESS_WAIT: begin
                if (key_s && (cnt_r == STABLE_LAST)) begin
                    level_nxt_s = 1'b1;
                    press_nxt_s = 1'b1;
                end else begin
                    level_nxt_s = level_r;
                end
            end
            S_PRESSED: begin
                if (key_s && (cnt_r == LONG_LAST)) begin
                    long_nxt_s = 1'b1;
                end else begin
                    long_nxt_s = 1'b0;
                end
            end
            S_RELEASE_WAIT: begin
                if (!key_s && (cnt_r == STABLE_LAST)) begin
                    level_nxt_s   = 1'b0;
                    release_nxt_s = 1'b1;
                end else begin
                    level_nxt_s   = level_r;
                end
            end
            default: begin
                level_nxt_s = 1'b0;
            end
        endcase
    end

    assign o_level   = level_r;
    assign o_press   = press_r;
    assign o_release = release_r;
    assign o_long    = long_r;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_CYCLES=4, LONG_CYCLES=10, CNT_W=4.
// Outputs are compared as {level, press, release, long} one time unit after each edge.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;
    logic level_s, press_s, release_s, long_s;

    int n_cmp = 0;
    int n_mis = 0;

    key_debounce #(
        .STABLE_CYCLES (4),
        .LONG_CYCLES   (10),
        .CNT_W         (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_key_n   (key_n),
        .o_level   (level_s),
        .o_press   (press_s),
        .o_release (release_s),
        .o_long    (long_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %b required %b (level,press,release,long)", tag, obs, exp);
        end
    endtask

    // Drive the key, take one rising edge, compare outputs just after it.
    task automatic step(input logic kn, input logic [3:0] exp, input string tag);
        key_n = kn;
        @(posedge clk);
        #1;
        check_eq(tag, {level_s, press_s, release_s, long_s}, exp);
    endtask

    task automatic do_reset(input logic kn, input string tag);
        rst   = 1'b1;
        key_n = kn;
        @(posedge clk);
        #1;
        check_eq(tag, {level_s, press_s, release_s, long_s}, 4'b0000);
        rst = 1'b0;
    endtask

    initial begin
        logic kn;

        do_reset(1'b1, "reset_idle");

        // Clean press held 20 edges; long-hold fires 10 edges after press.
        for (int k = 0; k < 20; k++)
            step(1'b0, {k >= 5, k == 5, 1'b0, k == 15}, $sformatf("clean_press[%0d]", k));

        // Release following the clean press.
        for (int j = 0; j < 10; j++)
            step(1'b1, {j < 5, 1'b0, j == 5, 1'b0}, $sformatf("release[%0d]", j));

        // Bounce: low 3, high 1, low 8; press 5 edges after the restart.
        do_reset(1'b1, "reset_bounce");
        for (int k = 0; k < 12; k++) begin
            kn = (k == 3) ? 1'b1 : 1'b0;
            step(kn, {k >= 9, k == 9, 1'b0, 1'b0}, $sformatf("bounce[%0d]", k));
        end

        // Long hold then a 2-cycle release glitch: no release, no second long.
        do_reset(1'b1, "reset_long");
        for (int k = 0; k < 47; k++) begin
            kn = (k == 30 || k == 31) ? 1'b1 : 1'b0;
            step(kn, {k >= 5, k == 5, 1'b0, k == 15}, $sformatf("long_hold[%0d]", k));
        end

        // Reset in press-wait, then again while the press pulse is high.
        do_reset(1'b1, "reset_mid_a");
        for (int k = 0; k < 3; k++)
            step(1'b0, 4'b0000, $sformatf("pre_wait[%0d]", k));
        do_reset(1'b0, "reset_in_press_wait");
        for (int k = 0; k < 6; k++)
            step(1'b0, {k >= 5, k == 5, 1'b0, 1'b0}, $sformatf("after_rst_a[%0d]", k));
        do_reset(1'b0, "reset_in_press_pulse");
        for (int k = 0; k < 8; k++)
            step(1'b0, {k >= 5, k == 5, 1'b0, 1'b0}, $sformatf("after_rst_b[%0d]", k));

        // Glitch train: single-cycle lows every 3 cycles never get through.
        do_reset(1'b1, "reset_glitch");
        for (int k = 0; k < 50; k++) begin
            kn = ((k % 3) == 0) ? 1'b0 : 1'b1;
            step(kn, 4'b0000, $sformatf("glitch[%0d]", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
